// File: rtl/kanagawa_stream_pkg.sv
// Shared stream-buffer types: occupancy encoding for small output buffers.
package kanagawa_stream_pkg;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_t;
  localparam int OCC_MAX = 2;
endpackage

// File: rtl/show_ahead_fifo_stream_drain.sv
// Drains a show-ahead FIFO into a valid/ready stream through a head+skid buffer,
// so the FIFO pop never depends combinationally on out_ready.
module show_ahead_fifo_stream_drain
  import kanagawa_stream_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_q,
  output logic                   fifo_rdreq,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] beat_count
);

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  occ_t             occ_q;
  occ_t             occ_d;
  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic             pop;
  logic             take;
  logic             wr0;
  logic             wr1;
  logic             shift;

  assign pop        = rst_n & ~fifo_empty & ~flush & (occ_q != OCC_TWO);
  assign fifo_rdreq = pop;
  assign out_valid  = (occ_q != OCC_EMPTY);
  assign take       = out_valid & out_ready;
  assign out_data   = entry0;
  assign occupancy  = occ_q;

  always_comb begin
    occ_d = occ_q;
    wr0   = 1'b0;
    wr1   = 1'b0;
    shift = 1'b0;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (pop) begin
            occ_d = OCC_ONE;
            wr0   = 1'b1;
          end
        end
        OCC_ONE: begin
          if (pop && !take) begin
            occ_d = OCC_TWO;
            wr1   = 1'b1;
          end else if (!pop && take) begin
            occ_d = OCC_EMPTY;
          end else if (pop && take) begin
            wr0 = 1'b1;
          end
        end
        OCC_TWO: begin
          if (take) begin
            occ_d = OCC_ONE;
            shift = 1'b1;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Control: occupancy state and delivered-beat counter
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
      beat_count <= '0;
    end else begin
      occ_q <= occ_d;
      if (take) beat_count <= sat_inc(beat_count);
    end
  end

  // Data: entry registers are qualified by occupancy, so they carry no reset
  always_ff @(posedge clock) begin
    if (wr0)        entry0 <= fifo_q;
    else if (shift) entry0 <= entry1;
    if (wr1)        entry1 <= fifo_q;
  end

`ifndef NO_DYNAMIC_ASSERTS
  a_no_underflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(fifo_rdreq && fifo_empty));
  a_hold_data: assert property (@(posedge clock) disable iff (!rst_n)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));
  a_occ_range: assert property (@(posedge clock) disable iff (!rst_n)
    occupancy <= 2'(OCC_MAX));
`endif

endmodule

// File: tb/tb_show_ahead_fifo_stream_drain.sv
// Scoreboard bench: a queue-based show-ahead FIFO feeds the DUT; a monitor checks each delivered beat.
module tb_show_ahead_fifo_stream_drain;
  localparam int WIDTH = 32;
  localparam int CW    = 4;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_q = '0;
  logic             fifo_rdreq;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CW-1:0]    beat_count;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] fifo_mem[$];
  logic [WIDTH-1:0] exp_q[$];

  show_ahead_fifo_stream_drain #(.WIDTH(WIDTH), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
    .beat_count(beat_count)
  );

  always #5 clock = ~clock;

  // Show-ahead FIFO model: flags and head update only at the clock edge
  always @(posedge clock) begin
    if (fifo_rdreq && fifo_mem.size() != 0) void'(fifo_mem.pop_front());
    fifo_empty <= (fifo_mem.size() == 0);
    fifo_q     <= (fifo_mem.size() != 0) ? fifo_mem[0] : '0;
  end

  always @(negedge clock) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got %0h want none", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL beat_data: got %0h want %0h", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input logic rdy);
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = rdy;
    exp_q.delete();
    fifo_mem.delete();
    repeat (3) @(posedge clock);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v, input bit expect_out);
    fifo_mem.push_back(v);
    if (expect_out) exp_q.push_back(v);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  initial begin
    int rd_cnt;
    int rd_first;
    int rd_last;
    int vld_first;

    // Reset state
    apply_reset(1'b1);
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("rst_rdreq", 32'(fifo_rdreq), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_beats", 32'(beat_count), 0);
    release_reset();
    repeat (2) tick();
    @(negedge clock);
    chk("idle_rdreq", 32'(fifo_rdreq), 0);
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_occ", 32'(occupancy), 0);
    chk("idle_beats", 32'(beat_count), 0);

    // Streaming 1..8 at full rate
    apply_reset(1'b1);
    for (int i = 1; i <= 8; i++) load(WIDTH'(i), 1'b1);
    release_reset();
    rd_cnt = 0; rd_first = -1; rd_last = -1; vld_first = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (fifo_rdreq) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = k;
        rd_last = k;
      end
      if (out_valid && vld_first < 0) vld_first = k;
    end
    chk("stream_rd_count", 32'(rd_cnt), 8);
    chk("stream_rd_span", 32'(rd_last - rd_first), 7);
    chk("stream_latency", 32'(vld_first - rd_first), 1);
    wait_drain(10);
    @(negedge clock);
    chk("stream_beats", 32'(beat_count), 8);

    // Back-pressure fills head+skid, then drains in order
    apply_reset(1'b0);
    load(32'hA, 1'b1); load(32'hB, 1'b1); load(32'hC, 1'b1);
    release_reset();
    rd_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (fifo_rdreq) rd_cnt++;
    end
    chk("bp_rd_count", 32'(rd_cnt), 2);
    chk("bp_occ", 32'(occupancy), 2);
    chk("bp_rdreq", 32'(fifo_rdreq), 0);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_hold_data", out_data, 32'hA);
    tick();
    out_ready = 1'b1;
    wait_drain(20);
    @(negedge clock);
    chk("bp_beats", 32'(beat_count), 3);

    // Flush at occupancy 2
    apply_reset(1'b0);
    load(32'h5, 1'b0); load(32'h6, 1'b0); load(32'h7, 1'b0);
    release_reset();
    repeat (3) @(negedge clock);
    chk("fl_pre_occ", 32'(occupancy), 2);
    tick();
    flush = 1'b1;
    @(negedge clock);
    chk("fl_rdreq_two", 32'(fifo_rdreq), 0);
    tick();
    @(negedge clock);
    chk("fl_occ", 32'(occupancy), 0);
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_beats", 32'(beat_count), 0);
    chk("fl_rdreq_empty", 32'(fifo_rdreq), 0);
    tick();
    flush = 1'b0;
    exp_q.push_back(32'h7);
    out_ready = 1'b1;
    @(negedge clock);
    chk("fl_resume_rdreq", 32'(fifo_rdreq), 1);
    wait_drain(10);
    @(negedge clock);
    chk("fl_post_beats", 32'(beat_count), 1);

    // Counter saturation with a 4-bit counter
    apply_reset(1'b1);
    for (int i = 0; i < 20; i++) load(WIDTH'(32'h10 + i), 1'b1);
    release_reset();
    wait_drain(60);
    @(negedge clock);
    chk("sat_beats", 32'(beat_count), 15);
    repeat (5) tick();
    @(negedge clock);
    chk("sat_hold", 32'(beat_count), 15);
    chk("sat_idle_valid", 32'(out_valid), 0);

    // Asynchronous reset mid-stream at occupancy 2
    apply_reset(1'b0);
    for (int i = 1; i <= 5; i++) load(WIDTH'(32'h30 + i), 1'b0);
    release_reset();
    repeat (3) @(negedge clock);
    chk("ar_pre_occ", 32'(occupancy), 2);
    @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_occ", 32'(occupancy), 0);
    chk("ar_rdreq", 32'(fifo_rdreq), 0);
    exp_q.push_back(32'h33); exp_q.push_back(32'h34); exp_q.push_back(32'h35);
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    wait_drain(20);
    @(negedge clock);
    chk("ar_beats", 32'(beat_count), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
